// File: rtl/sensor_interface_multi.sv
// Multi-channel DHT11 request front end: decodes byte requests from the UART
// command path, runs one sensor read at a time on the addressed channel, and
// returns a response byte plus a one-hot command code with a one-cycle strobe.

// Per-channel frame decode: checksum check and the two integer fields that a
// response can carry. One instance per channel keeps the frame layout in a
// single place.
module sensor_ch_slice (
    input  logic [39:0] data,
    output logic        crc_ok,
    output logic [7:0]  hum_int,
    output logic [7:0]  temp_int
);
    logic [7:0] sum;

    // Modulo-256 sum of the four payload bytes against the trailing crc byte
    assign sum      = data[39:32] + data[31:24] + data[23:16] + data[15:8];
    assign crc_ok   = (sum == data[7:0]);
    assign hum_int  = data[39:32];
    assign temp_int = data[23:16];
endmodule

module sensor_interface_multi #(
    parameter int N_CH        = 4,
    parameter int CH_W        = 4,
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Req_Valid,
    input  logic [CH_W-1:0]      i_Ch,
    input  logic [7:0]           i_Request,
    output logic                 o_Busy,
    output logic [N_CH-1:0]      o_Sensor_Start,
    input  logic [N_CH-1:0]      i_Sensor_Done,
    input  logic [N_CH-1:0]      i_Sensor_Error,
    input  logic [40*N_CH-1:0]   i_Sensor_Data,
    output logic [7:0]           o_Data,
    output logic [5:0]           o_Comandos,
    output logic                 o_Done
);
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [5:0] CMD_ERR  = 6'b000001;
    localparam logic [5:0] CMD_ACT  = 6'b000010;
    localparam logic [5:0] CMD_HUM  = 6'b000100;
    localparam logic [5:0] CMD_TEMP = 6'b001000;
    localparam logic [5:0] CMD_D36  = 6'b010000;
    localparam logic [5:0] CMD_D37  = 6'b100000;

    localparam logic [7:0] ERR_SENS = 8'h86;
    localparam logic [7:0] ERR_CRC  = 8'h87;
    localparam logic [7:0] ERR_TO   = 8'h88;
    localparam logic [7:0] ERR_CH   = 8'h89;
    localparam logic [7:0] ERR_REQ  = 8'h8A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_RESP
    } state_t;

    state_t state, nxt;

    logic [CH_W-1:0]      ch_q;
    logic [7:0]           req_q;
    logic [TO_W-1:0]      cnt;
    logic                 err_q, to_q, crc_q;
    logic [7:0]           hum_q, temp_q;
    logic [5:0]           resp_cmd;
    logic [7:0]           resp_data;

    logic                 accept, ch_bad, go_sensor;
    logic [5:0]           imm_cmd, chk_cmd;
    logic [7:0]           imm_data, chk_data;
    logic                 sel_done, sel_err, sel_crc;
    logic [7:0]           sel_hum, sel_temp;
    logic                 wait_exit;
    logic [N_CH-1:0]      start_nxt;

    logic [N_CH-1:0]      ch_crc_ok;
    logic [N_CH-1:0][7:0] ch_hum;
    logic [N_CH-1:0][7:0] ch_temp;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        sensor_ch_slice u_slice (
            .data     (i_Sensor_Data[40*c +: 40]),
            .crc_ok   (ch_crc_ok[c]),
            .hum_int  (ch_hum[c]),
            .temp_int (ch_temp[c])
        );
    end

    assign accept    = (state == S_IDLE) && i_Req_Valid;
    assign ch_bad    = ({1'b0, i_Ch} >= (CH_W+1)'(N_CH));
    assign o_Busy    = (state != S_IDLE);
    assign wait_exit = sel_done || sel_err || (cnt == CNT_LAST);

    // Pick the latched channel's status and decoded fields
    always_comb begin
        sel_done = 1'b0;
        sel_err  = 1'b0;
        sel_crc  = 1'b0;
        sel_hum  = 8'h00;
        sel_temp = 8'h00;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
                sel_done = i_Sensor_Done[c];
                sel_err  = i_Sensor_Error[c];
                sel_crc  = ch_crc_ok[c];
                sel_hum  = ch_hum[c];
                sel_temp = ch_temp[c];
            end
        end
    end

    // Decode a request in IDLE: immediate answer, or hand off to a sensor read
    always_comb begin
        imm_cmd   = CMD_ERR;
        imm_data  = ERR_REQ;
        go_sensor = 1'b0;
        if (ch_bad) begin
            imm_data = ERR_CH;
        end else begin
            case (i_Request)
                8'h36:               begin imm_cmd = CMD_D36; imm_data = 8'h00; end
                8'h37:               begin imm_cmd = CMD_D37; imm_data = 8'h00; end
                8'h31, 8'h32, 8'h33: go_sensor = 1'b1;
                default:             ;
            endcase
        end
    end

    // Post-read response: sensor error beats timeout beats checksum failure
    always_comb begin
        chk_cmd  = CMD_ERR;
        chk_data = ERR_REQ;
        if (err_q) begin
            chk_data = ERR_SENS;
        end else if (to_q) begin
            chk_data = ERR_TO;
        end else if (!crc_q) begin
            chk_data = ERR_CRC;
        end else begin
            case (req_q)
                8'h31:   begin chk_cmd = CMD_ACT;  chk_data = 8'h00;  end
                8'h32:   begin chk_cmd = CMD_TEMP; chk_data = temp_q; end
                8'h33:   begin chk_cmd = CMD_HUM;  chk_data = hum_q;  end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (i_Req_Valid) nxt = go_sensor ? S_START : S_RESP;
            S_START: nxt = S_WAIT;
            S_WAIT:  if (wait_exit) nxt = S_CHECK;
            S_CHECK: nxt = S_RESP;
            S_RESP:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Start level is high exactly for the cycles spent in WAIT
    always_comb begin
        start_nxt = '0;
        for (int c = 0; c < N_CH; c++)
            start_nxt[c] = (nxt == S_WAIT) && (ch_q == CH_W'(c));
    end

    // State register
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= S_IDLE;
        else          state <= nxt;
    end

    // Request latch, timeout counter, read result capture and response regs
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            ch_q           <= '0;
            req_q          <= 8'h00;
            cnt            <= '0;
            err_q          <= 1'b0;
            to_q           <= 1'b0;
            crc_q          <= 1'b0;
            hum_q          <= 8'h00;
            temp_q         <= 8'h00;
            resp_cmd       <= 6'b0;
            resp_data      <= 8'h00;
            o_Data         <= 8'h00;
            o_Comandos     <= 6'b0;
            o_Done         <= 1'b0;
            o_Sensor_Start <= '0;
        end else begin
            o_Done         <= (state == S_RESP);
            o_Sensor_Start <= start_nxt;
            if (accept) begin
                ch_q       <= i_Ch;
                req_q      <= i_Request;
                resp_cmd   <= imm_cmd;
                resp_data  <= imm_data;
                o_Data     <= 8'h00;
                o_Comandos <= 6'b0;
            end
            case (state)
                S_START: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (wait_exit) begin
                        err_q  <= sel_err;
                        to_q   <= !sel_done && !sel_err;
                        crc_q  <= sel_crc;
                        hum_q  <= sel_hum;
                        temp_q <= sel_temp;
                    end
                end
                S_CHECK: begin
                    resp_cmd  <= chk_cmd;
                    resp_data <= chk_data;
                end
                S_RESP: begin
                    o_Data     <= resp_data;
                    o_Comandos <= resp_cmd;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sensor_interface_multi.sv
// Directed bench for sensor_interface_multi with a short timeout (100 cycles).
module tb_sensor_interface_multi;
    localparam int N_CH = 4;
    localparam int CH_W = 4;
    localparam int TOC  = 100;

    logic                 clk;
    logic                 rst_n;
    logic                 req_valid;
    logic [CH_W-1:0]      ch;
    logic [7:0]           request;
    logic                 busy;
    logic [N_CH-1:0]      sstart;
    logic [N_CH-1:0]      sdone;
    logic [N_CH-1:0]      serr;
    logic [40*N_CH-1:0]   sdata;
    logic [7:0]           data;
    logic [5:0]           cmd;
    logic                 done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    sensor_interface_multi #(.N_CH(N_CH), .CH_W(CH_W), .TIMEOUT_CYC(TOC)) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Req_Valid    (req_valid),
        .i_Ch           (ch),
        .i_Request      (request),
        .o_Busy         (busy),
        .o_Sensor_Start (sstart),
        .i_Sensor_Done  (sdone),
        .i_Sensor_Error (serr),
        .i_Sensor_Data  (sdata),
        .o_Data         (data),
        .o_Comandos     (cmd),
        .o_Done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    // Drive a one-cycle request; returns at the negedge after the accept edge
    task automatic issue(input logic [CH_W-1:0] c, input logic [7:0] r);
        @(negedge clk);
        req_valid = 1'b1; ch = c; request = r;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Count negedges until o_Done is seen, bounded
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 400);
    endtask

    task automatic test_reset;
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (sstart !== 4'b0) begin bad++; $display("FAIL reset_start got=%b want=0000", sstart); end
        total++; if (data !== 8'h00 || cmd !== 6'b0 || done !== 1'b0)
            begin bad++; $display("FAIL reset_out got=%h/%b/%b want=00/000000/0", data, cmd, done); end
    endtask

    task automatic test_read_temp;
        int cyc;
        sdata[40*1 +: 40] = {8'd40, 8'd0, 8'd25, 8'd0, 8'd65};
        issue(4'd1, 8'h32);
        @(negedge clk);
        total++; if (sstart !== 4'b0010 || busy !== 1'b1)
            begin bad++; $display("FAIL temp_start got=%b busy=%b want=0010 busy=1", sstart, busy); end
        sdone[1] = 1'b1;
        wait_done(cyc);
        total++; if (cyc !== 3) begin bad++; $display("FAIL temp_latency got=%0d want=3", cyc); end
        total++; if (cmd !== 6'b001000 || data !== 8'h19)
            begin bad++; $display("FAIL temp_resp got=%b/%h want=001000/19", cmd, data); end
        total++; if (sstart !== 4'b0) begin bad++; $display("FAIL temp_start_off got=%b want=0000", sstart); end
        sdone[1] = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b0 || data !== 8'h19)
            begin bad++; $display("FAIL temp_pulse got done=%b data=%h want 0/19", done, data); end
    endtask

    task automatic test_crc_and_error;
        int cyc;
        sdata[40*1 +: 40] = {8'd40, 8'd0, 8'd25, 8'd0, 8'd66};
        issue(4'd1, 8'h32);
        @(negedge clk);
        sdone[1] = 1'b1;
        wait_done(cyc);
        total++; if (cyc !== 3 || cmd !== 6'b000001 || data !== 8'h87)
            begin bad++; $display("FAIL crc_fail got=%0d %b/%h want=3 000001/87", cyc, cmd, data); end
        sdone[1] = 1'b0;
        sdata[40*1 +: 40] = {8'd40, 8'd0, 8'd25, 8'd0, 8'd65};
        issue(4'd1, 8'h32);
        @(negedge clk);
        sdone[1] = 1'b1; serr[1] = 1'b1;
        wait_done(cyc);
        total++; if (cyc !== 3 || cmd !== 6'b000001 || data !== 8'h86)
            begin bad++; $display("FAIL sens_err got=%0d %b/%h want=3 000001/86", cyc, cmd, data); end
        sdone[1] = 1'b0; serr[1] = 1'b0;
    endtask

    task automatic test_timeout;
        int hi, n, cyc;
        logic other;
        sdata[40*2 +: 40] = {8'd10, 8'd1, 8'd20, 8'd2, 8'd33};
        hi = 0; n = 0; other = 1'b0;
        issue(4'd2, 8'h31);
        do begin
            @(negedge clk);
            n++;
            if (sstart[2]) hi++;
            if ((sstart & 4'b1011) != 4'b0) other = 1'b1;
        end while (!done && n < 400);
        total++; if (hi !== TOC) begin bad++; $display("FAIL to_start_cycles got=%0d want=%0d", hi, TOC); end
        total++; if (n !== TOC + 3) begin bad++; $display("FAIL to_latency got=%0d want=%0d", n, TOC + 3); end
        total++; if (cmd !== 6'b000001 || data !== 8'h88 || other !== 1'b0)
            begin bad++; $display("FAIL to_resp got=%b/%h other=%b want=000001/88 0", cmd, data, other); end
        // done shows up in the very last WAIT cycle: done must win
        hi = 0;
        issue(4'd2, 8'h31);
        for (int i = 0; i < TOC; i++) begin
            @(negedge clk);
            if (sstart[2]) hi++;
        end
        sdone[2] = 1'b1;
        wait_done(cyc);
        total++; if (hi !== TOC || cyc !== 3)
            begin bad++; $display("FAIL to_edge_timing got hi=%0d cyc=%0d want %0d/3", hi, cyc, TOC); end
        total++; if (cmd !== 6'b000010 || data !== 8'h00)
            begin bad++; $display("FAIL to_edge_resp got=%b/%h want=000010/00", cmd, data); end
        sdone[2] = 1'b0;
    endtask

    task automatic test_immediate;
        logic [CH_W-1:0] cs [4]  = '{4'd4, 4'd0, 4'd0, 4'd15};
        logic [7:0]      rs [4]  = '{8'h32, 8'h36, 8'h41, 8'h37};
        logic [5:0]      ec [4]  = '{6'b000001, 6'b010000, 6'b000001, 6'b000001};
        logic [7:0]      ed [4]  = '{8'h89, 8'h00, 8'h8A, 8'h89};
        for (int k = 0; k < 4; k++) begin
            issue(cs[k], rs[k]);
            total++; if (done !== 1'b0 || busy !== 1'b1 || data !== 8'h00 || cmd !== 6'b0)
                begin bad++; $display("FAIL imm%0d_accept got done=%b busy=%b %h/%b want 0 1 00/000000", k, done, busy, data, cmd); end
            @(negedge clk);
            total++; if (done !== 1'b1 || cmd !== ec[k] || data !== ed[k] || sstart !== 4'b0)
                begin bad++; $display("FAIL imm%0d_resp got done=%b %b/%h st=%b want 1 %b/%h 0000", k, done, cmd, data, sstart, ec[k], ed[k]); end
            @(negedge clk);
            total++; if (done !== 1'b0 || busy !== 1'b0 || data !== ed[k])
                begin bad++; $display("FAIL imm%0d_hold got done=%b busy=%b data=%h want 0 0 %h", k, done, busy, data, ed[k]); end
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        sdata[40*3 +: 40] = {8'd55, 8'd5, 8'd20, 8'd3, 8'd83};
        issue(4'd3, 8'h33);
        repeat (5) @(negedge clk);
        total++; if (sstart !== 4'b1000) begin bad++; $display("FAIL rst_pre_start got=%b want=1000", sstart); end
        rst_n = 1'b0;
        #1;
        total++; if (sstart !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || data !== 8'h00 || cmd !== 6'b0)
            begin bad++; $display("FAIL rst_mid got st=%b busy=%b done=%b %h/%b want all 0", sstart, busy, done, data, cmd); end
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd3, 8'h33);
        @(negedge clk);
        sdone[3] = 1'b1;
        wait_done(cyc);
        total++; if (cyc !== 3 || cmd !== 6'b000100 || data !== 8'h37)
            begin bad++; $display("FAIL rst_after got=%0d %b/%h want=3 000100/37", cyc, cmd, data); end
        sdone[3] = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc, d0;
        sdata[40*0 +: 40] = {8'd30, 8'd2, 8'd21, 8'd4, 8'd57};
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        issue(4'd0, 8'h32);
        @(negedge clk);
        req_valid = 1'b1; ch = 4'd0; request = 8'h36;
        @(negedge clk);
        req_valid = 1'b0;
        sdone[0] = 1'b1;
        wait_done(cyc);
        total++; if (cyc !== 3 || cmd !== 6'b001000 || data !== 8'h15 || busy !== 1'b0)
            begin bad++; $display("FAIL b2b_first got=%0d %b/%h busy=%b want=3 001000/15 0", cyc, cmd, data, busy); end
        sdone[0] = 1'b0;
        req_valid = 1'b1; ch = 4'd0; request = 8'h37;
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0 || data !== 8'h00 || cmd !== 6'b0)
            begin bad++; $display("FAIL b2b_accept got busy=%b done=%b %h/%b want 1 0 00/000000", busy, done, data, cmd); end
        @(negedge clk);
        total++; if (done !== 1'b1 || cmd !== 6'b100000 || data !== 8'h00)
            begin bad++; $display("FAIL b2b_second got done=%b %b/%h want 1 100000/00", done, cmd, data); end
        repeat (4) @(negedge clk);
        total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", done_cnt - d0); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; ch = '0; request = 8'h00;
        sdone = '0; serr = '0; sdata = '0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_read_temp;
        test_crc_and_error;
        test_timeout;
        test_immediate;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
